// File: rtl/rf_sb_bypass.sv
// rtl/rf_sb_bypass.sv - register file with per-register pending scoreboard and write-to-read bypass
module rf_sb_bypass #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic [DATA_W-1:0] o_rd_data1,
    output logic [DATA_W-1:0] o_rd_data2,
    output logic              o_rd_busy1,
    output logic              o_rd_busy2,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_alloc_en,
    input  logic [ADDR_W-1:0] i_alloc_addr,
    output logic [ADDR_W:0]   o_pending_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [ADDR_W:0]   cnt;

    logic wr_ok;
    logic al_ok;
    logic byp_ok;
    logic cnt_inc;
    logic cnt_dec;

    function automatic logic is_prot(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wr_ok  = i_wr_en && !is_prot(i_wr_addr);
    assign al_ok  = i_alloc_en && !is_prot(i_alloc_addr);
    // A write held during reset is discarded, so it must not be forwarded either.
    assign byp_ok = wr_ok && i_rst_n;

    always_comb begin
        pend_nxt = pend;
        if (wr_ok) pend_nxt[i_wr_addr] = 1'b0;
        if (al_ok) pend_nxt[i_alloc_addr] = 1'b1;
    end

    // A same-edge write and allocate to one register leaves it pending, so no decrement.
    assign cnt_inc = al_ok && !pend[i_alloc_addr];
    assign cnt_dec = wr_ok && pend[i_wr_addr] && !(al_ok && (i_alloc_addr == i_wr_addr));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend <= '0;
            cnt  <= '0;
        end else begin
            pend <= pend_nxt;
            cnt  <= cnt + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
        end
    end

    assign o_pending_cnt = cnt;

    always_comb begin
        o_rd_data1 = mem[i_rd_addr1];
        o_rd_busy1 = pend[i_rd_addr1];
        if (is_prot(i_rd_addr1)) begin
            o_rd_data1 = '0;
            o_rd_busy1 = 1'b0;
        end else if (byp_ok && (i_wr_addr == i_rd_addr1)) begin
            o_rd_data1 = i_wr_data;
            o_rd_busy1 = 1'b0;
        end
    end

    always_comb begin
        o_rd_data2 = mem[i_rd_addr2];
        o_rd_busy2 = pend[i_rd_addr2];
        if (is_prot(i_rd_addr2)) begin
            o_rd_data2 = '0;
            o_rd_busy2 = 1'b0;
        end else if (byp_ok && (i_wr_addr == i_rd_addr2)) begin
            o_rd_data2 = i_wr_data;
            o_rd_busy2 = 1'b0;
        end
    end

endmodule
